sr_pq_ctrl: RTL and testbench

Front-end controller for the shift-register priority queue (a chain of DEPTH `sr_pq_stage` instances, stage 0 = minimum key). It arbitrates NREQ push requesters round-robin, serves a single pop consumer, and drives the queue's shared `push`/`pop`/`kvi` broadcast. It tracks occupancy and hides the queue's unsafe simultaneous push/pop case (new key below head) with a bypass path. It also sequences a flush that drains the queue without a reset.

---
 rtl/sr_pq_pkg.sv | 21 ++
 rtl/sr_pq_ctrl_rr_arb.sv | 57 +++++
 rtl/sr_pq_ctrl.sv | 150 +++++++++++++++
 tb/tb_sr_pq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pq_pkg.sv
// Shared types and constants for the shift-register priority queue front-end.
// The state encoding is exposed both as an enum and as plain logic constants.
package sr_pq_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  localparam logic [0:0] ST_RUN   = RUN;
  localparam logic [0:0] ST_FLUSH = FLUSH;

  // Empty stages hold an all-ones key with a zero value, so they sort last.
  localparam logic KEYINF_BIT = 1'b1;
  localparam logic VAL0_BIT   = 1'b0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sr_pq_ctrl_rr_arb.sv
// Round-robin arbiter: one-hot grant among asserted requests, starting at the
// internal pointer; the pointer moves past the winner only when a grant issues.
module rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] jj;
  logic [PW:0]   j;
  logic [N-1:0]  pick;
  logic          found;
  logic          take;

  always_comb begin
    pick     = '0;
    pick_idx = ptr;
    found    = 1'b0;
    take     = 1'b0;
    j        = '0;
    jj       = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr} + (PW+1)'(i);
      if (j >= (PW+1)'(N)) begin
        j = j - (PW+1)'(N);
      end else begin
        j = j;
      end
      jj       = j[PW-1:0];
      take     = en && !found && req[jj];
      pick     = pick | (N'(take) << jj);
      pick_idx = take ? jj : pick_idx;
      found    = found | take;
    end
  end

  assign gnt = pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (pick_idx == PW'(N - 1)) ? '0 : pick_idx + PW'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/sr_pq_ctrl.sv
// Front-end controller for the shift-register priority queue: push arbitration,
// pop service with a head-bypass for keys below the head, occupancy and flush.
module sr_pq_ctrl
  import sr_pq_pkg::*;
#(
  parameter  int KW    = 4,
  parameter  int VW    = 4,
  parameter  int DEPTH = 8,
  parameter  int NREQ  = 4,
  localparam int KVW   = KW + VW,
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           push_req,
  input  logic [NREQ-1:0][KVW-1:0]  push_kv,
  output logic [NREQ-1:0]           push_gnt,
  input  logic                      pop_req,
  output logic                      pop_gnt,
  output logic                      pop_valid,
  output logic [KVW-1:0]            pop_kv,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic                      pq_push,
  output logic                      pq_pop,
  output logic [KVW-1:0]            pq_kvi,
  input  logic [KVW-1:0]            pq_head,
  output logic [CW-1:0]             count,
  output logic                      full,
  output logic                      empty,
  output logic                      err_inf
);

  localparam logic [KW-1:0] KEYINF = {KW{KEYINF_BIT}};
  localparam logic [VW-1:0] VAL0   = {VW{VAL0_BIT}};

  logic [0:0]      state;
  logic            run;
  logic            push_en;
  logic            push_fire;
  logic            push_fwd;
  logic            sel_inf;
  logic            byp;
  logic [KVW-1:0]  sel_kv;
  logic [KW-1:0]   sel_key;
  logic [KW-1:0]   head_key;
  logic [CW-1:0]   cnt_nxt;

  assign run = (state == ST_RUN) && !rst;

  // A full queue can still take a push when the pop frees a slot in the same cycle.
  assign push_en = run && (!full || pop_req);

  rr_arb #(
    .N   (NREQ)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (push_req),
    .en  (push_en),
    .gnt (push_gnt)
  );

  always_comb begin
    sel_kv = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_kv = sel_kv | ({KVW{push_gnt[i]}} & push_kv[i]);
    end
  end

  assign sel_key   = sel_kv[KVW-1:VW];
  assign head_key  = pq_head[KVW-1:VW];
  assign push_fire = |push_gnt;
  assign sel_inf   = (sel_key == KEYINF);
  assign push_fwd  = push_fire && !sel_inf;

  // The queue cannot insert below its head while popping, so that entry goes straight out.
  assign byp = push_fwd && pop_req && (sel_key < head_key);

  always_comb begin
    pop_gnt = 1'b0;
    pq_push = 1'b0;
    pq_pop  = 1'b0;
    pq_kvi  = '0;
    if (rst) begin
      pop_gnt = 1'b0;
    end else if (state == ST_FLUSH) begin
      pq_pop = (count != '0);
    end else begin
      pop_gnt = pop_req && ((count != '0) || byp);
      pq_push = push_fwd && !byp;
      pq_pop  = pop_gnt && !byp;
      pq_kvi  = pq_push ? sel_kv : '0;
    end
  end

  always_comb begin
    cnt_nxt = count;
    if (pq_push && !pq_pop) begin
      cnt_nxt = count + CW'(1);
    end else if (pq_pop && !pq_push) begin
      cnt_nxt = count - CW'(1);
    end else begin
      cnt_nxt = count;
    end
  end

  assign flush_done = !rst && (state == ST_FLUSH) && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      pop_valid <= 1'b0;
      pop_kv    <= {KEYINF, VAL0};
      err_inf   <= 1'b0;
    end else begin
      count     <= cnt_nxt;
      full      <= (cnt_nxt == CW'(DEPTH));
      empty     <= (cnt_nxt == '0);
      pop_valid <= pop_gnt;
      err_inf   <= push_fire && sel_inf;
      if (pop_gnt) begin
        pop_kv <= byp ? sel_kv : pq_head;
      end else begin
        pop_kv <= pop_kv;
      end
      case (state)
        ST_RUN: begin
          if (flush_req) begin
            state <= ST_FLUSH;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (count == '0) begin
            state <= ST_RUN;
          end else begin
            state <= ST_FLUSH;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_pq_ctrl.sv
// Directed bench for sr_pq_ctrl with a behavioural sorted-queue model standing in
// for the stage chain; vectors carry hand-computed expectations.
module tb_sr_pq_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      push_req;
  logic [3:0][7:0] push_kv;
  logic [3:0]      push_gnt;
  logic            pop_req;
  logic            pop_gnt;
  logic            pop_valid;
  logic [7:0]      pop_kv;
  logic            flush_req;
  logic            flush_done;
  logic            pq_push;
  logic            pq_pop;
  logic [7:0]      pq_kvi;
  logic [7:0]      pq_head;
  logic [3:0]      count;
  logic            full;
  logic            empty;
  logic            err_inf;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sr_pq_ctrl #(.KW(4), .VW(4), .DEPTH(8), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .push_kv(push_kv), .push_gnt(push_gnt),
    .pop_req(pop_req), .pop_gnt(pop_gnt), .pop_valid(pop_valid), .pop_kv(pop_kv),
    .flush_req(flush_req), .flush_done(flush_done), .pq_push(pq_push), .pq_pop(pq_pop),
    .pq_kvi(pq_kvi), .pq_head(pq_head), .count(count), .full(full), .empty(empty),
    .err_inf(err_inf)
  );

  // Sorted queue model of the stage chain; ties insert behind equal keys.
  logic [7:0] q [0:7];
  int qn = 0;
  assign pq_head = (qn > 0) ? q[0] : 8'hF0;

  always @(posedge clk) begin : qmodel
    logic [7:0] t [0:8];
    int tn;
    int p;
    for (int i = 0; i < 8; i++) t[i] = q[i];
    t[8] = 8'h00;
    tn = qn;
    if (rst) begin
      tn = 0;
    end else begin
      if (pq_pop && tn > 0) begin
        for (int i = 0; i < 8; i++) t[i] = t[i+1];
        tn = tn - 1;
      end
      if (pq_push) begin
        p = tn;
        for (int i = 0; i < 8; i++)
          if (i < tn && p == tn && t[i][7:4] > pq_kvi[7:4]) p = i;
        for (int i = 8; i > 0; i--)
          if (i > p) t[i] = t[i-1];
        t[p] = pq_kvi;
        tn = tn + 1;
      end
    end
    for (int i = 0; i < 8; i++) q[i] <= t[i];
    qn <= tn;
  end

  typedef struct {
    logic [3:0]  preq;
    logic [31:0] pkv;
    logic        pop;
    logic [3:0]  e_gnt;
    logic        e_popg;
    logic        e_push;
    logic        e_pop;
    logic [3:0]  e_cnt;
    logic [7:0]  e_kv;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  function automatic vec_t mk(input logic [3:0] preq, input logic [31:0] pkv, input logic pop,
                              input logic [3:0] eg, input logic ep, input logic epu,
                              input logic epo, input logic [3:0] ec, input logic [7:0] ekv,
                              input logic ee);
    vec_t r;
    r.preq = preq; r.pkv = pkv; r.pop = pop; r.e_gnt = eg; r.e_popg = ep;
    r.e_push = epu; r.e_pop = epo; r.e_cnt = ec; r.e_kv = ekv; r.e_err = ee;
    return r;
  endfunction

  function automatic logic [7:0] exp_kvi(input vec_t x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) if (x.e_gnt[i]) r = x.pkv[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_count(input string nm, input logic [3:0] ec);
    chk({nm, "_count"}, count, ec);
    chk({nm, "_full"}, full, (ec == 4'd8));
    chk({nm, "_empty"}, empty, (ec == 4'd0));
  endtask

  initial begin
    // preq, push_kv, pop | gnt, pop_gnt, pq_push, pq_pop, count, pop_kv, err_inf
    tbl.push_back(mk(4'b0001, 32'h00000051, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0010, 32'h00002200, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0100, 32'h00930000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd2, 8'h22, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd1, 8'h51, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd0, 8'h93, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0001, 32'h00000034, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd0, 8'h34, 1'b0));
    tbl.push_back(mk(4'b0010, 32'h00004100, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0100, 32'h00720000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0));
    tbl.push_back(mk(4'b1000, 32'h13000000, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 4'd2, 8'h13, 1'b0));
    tbl.push_back(mk(4'b1000, 32'h65000000, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 4'd2, 8'h41, 1'b0));
    tbl.push_back(mk(4'b1111, 32'hA3B2C1D0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0));
    tbl.push_back(mk(4'b1111, 32'hA3B2C1D0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd4, 8'h00, 1'b0));
    tbl.push_back(mk(4'b1111, 32'hA3B2C1D0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0));
    tbl.push_back(mk(4'b1111, 32'hA3B2C1D0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'd6, 8'h00, 1'b0));
    tbl.push_back(mk(4'b1111, 32'hA3B2C1D0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0010, 32'h0000F500, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd7, 8'h00, 1'b1));
    tbl.push_back(mk(4'b0100, 32'h00E20000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd8, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0001, 32'h00000088, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd8, 8'h00, 1'b0));
    tbl.push_back(mk(4'b0001, 32'h00000088, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'd8, 8'h65, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd7, 8'h72, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd6, 8'h88, 1'b0));
    tbl.push_back(mk(4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 4'd5, 8'hA3, 1'b0));

    // Reset with every request active: controls must stay quiet.
    rst = 1'b1; push_req = 4'hF; push_kv = 32'hA3B2C1D0; pop_req = 1'b1; flush_req = 1'b1;
    tick();
    tick();
    chk("rst_push_gnt", push_gnt, 4'b0000);
    chk("rst_pq_push", pq_push, 1'b0);
    chk("rst_pq_pop", pq_pop, 1'b0);
    chk("rst_pop_gnt", pop_gnt, 1'b0);
    rst = 1'b0; push_req = 4'h0; push_kv = 32'h0; pop_req = 1'b0; flush_req = 1'b0;
    #1;
    chk_count("rst", 4'd0);
    chk("rst_pop_valid", pop_valid, 1'b0);
    chk("rst_pop_kv", pop_kv, 8'hF0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_err_inf", err_inf, 1'b0);
    tick();

    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      push_req = v.preq; push_kv = v.pkv; pop_req = v.pop; flush_req = 1'b0;
      #1;
      chk($sformatf("v%0d_push_gnt", k), push_gnt, v.e_gnt);
      chk($sformatf("v%0d_pop_gnt", k), pop_gnt, v.e_popg);
      chk($sformatf("v%0d_pq_push", k), pq_push, v.e_push);
      chk($sformatf("v%0d_pq_pop", k), pq_pop, v.e_pop);
      if (v.e_push) chk($sformatf("v%0d_pq_kvi", k), pq_kvi, exp_kvi(v));
      tick();
      chk_count($sformatf("v%0d", k), v.e_cnt);
      chk($sformatf("v%0d_pop_valid", k), pop_valid, v.e_popg);
      chk($sformatf("v%0d_err_inf", k), err_inf, v.e_err);
      if (v.e_popg) chk($sformatf("v%0d_pop_kv", k), pop_kv, v.e_kv);
    end

    // Flush of five entries while pushers and the consumer keep requesting.
    push_req = 4'h0; pop_req = 1'b0; flush_req = 1'b1;
    #1;
    chk("fl_enter_pq_pop", pq_pop, 1'b0);
    chk("fl_enter_done", flush_done, 1'b0);
    tick();
    flush_req = 1'b0; push_req = 4'hF; push_kv = 32'hA3B2C1D0; pop_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("fl%0d_pq_pop", c), pq_pop, 1'b1);
      chk($sformatf("fl%0d_push_gnt", c), push_gnt, 4'b0000);
      chk($sformatf("fl%0d_pop_gnt", c), pop_gnt, 1'b0);
      chk($sformatf("fl%0d_pq_push", c), pq_push, 1'b0);
      chk($sformatf("fl%0d_done", c), flush_done, 1'b0);
      tick();
      chk($sformatf("fl%0d_count", c), count, 4'(4 - c));
    end
    #1;
    chk("fl_done_pulse", flush_done, 1'b1);
    chk("fl_done_pq_pop", pq_pop, 1'b0);
    chk("fl_done_push_gnt", push_gnt, 4'b0000);
    tick();
    chk("fl_after_empty", empty, 1'b1);
    push_req = 4'b0001; push_kv = 32'h00000031; pop_req = 1'b0;
    #1;
    chk("fl_run_done", flush_done, 1'b0);
    chk("fl_run_push_gnt", push_gnt, 4'b0001);
    tick();
    chk_count("fl_run", 4'd1);

    // Reset on the second flush cycle discards the queue and the flush.
    push_req = 4'b0010; push_kv = 32'h00004200;
    tick();
    push_req = 4'b0100; push_kv = 32'h00530000;
    tick();
    chk_count("fr_fill", 4'd3);
    push_req = 4'h0; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    chk("fr_c1_pq_pop", pq_pop, 1'b1);
    tick();
    chk("fr_c1_count", count, 4'd2);
    rst = 1'b1; push_req = 4'hF; push_kv = 32'hA3B2C1D0;
    #1;
    chk("fr_rst_pq_pop", pq_pop, 1'b0);
    chk("fr_rst_push_gnt", push_gnt, 4'b0000);
    chk("fr_rst_done", flush_done, 1'b0);
    tick();
    rst = 1'b0; push_req = 4'h0;
    chk_count("fr_rst", 4'd0);
    chk("fr_rst_pop_valid", pop_valid, 1'b0);
    chk("fr_rst_pop_kv", pop_kv, 8'hF0);
    push_req = 4'b0001; push_kv = 32'h00000011;
    #1;
    chk("fr_run_push_gnt", push_gnt, 4'b0001);
    chk("fr_run_pq_push", pq_push, 1'b1);
    chk("fr_run_done", flush_done, 1'b0);
    tick();
    chk_count("fr_run", 4'd1);
    push_req = 4'h0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
